// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file port controller.
package regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 8;

  localparam logic [RF_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Client-facing bus of the register-file port controller: operand reads and writebacks.
interface regfile_port_ctrl_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_rs1;
  logic [ADDR_WIDTH-1:0] req_rs2;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_op1;
  logic [DATA_WIDTH-1:0] rsp_op2;

  logic                  wb0_valid;
  logic [ADDR_WIDTH-1:0] wb0_addr;
  logic [DATA_WIDTH-1:0] wb0_data;
  logic                  wb1_valid;
  logic [ADDR_WIDTH-1:0] wb1_addr;
  logic [DATA_WIDTH-1:0] wb1_data;
  logic                  wb_ready;
  logic                  wb_empty;

  modport master (
    output req_valid, req_rs1, req_rs2, rsp_ready,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  req_ready, rsp_valid, rsp_op1, rsp_op2, wb_ready, wb_empty
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, rsp_ready,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output req_ready, rsp_valid, rsp_op1, rsp_op2, wb_ready, wb_empty
  );

endinterface

// File: rtl/regfile_wbuf.sv
// Writeback FIFO: two enqueues and one drain per cycle, plus youngest-match lookup ports.
module regfile_wbuf
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in0_valid,
  input  logic [ADDR_WIDTH-1:0]      in0_addr,
  input  logic [DATA_WIDTH-1:0]      in0_data,
  input  logic                       in1_valid,
  input  logic [ADDR_WIDTH-1:0]      in1_addr,
  input  logic [DATA_WIDTH-1:0]      in1_data,
  output logic                       ready,
  output logic                       empty,
  output logic                       head_valid,
  output logic [ADDR_WIDTH-1:0]      head_addr,
  output logic [DATA_WIDTH-1:0]      head_data,
  input  logic [1:0][ADDR_WIDTH-1:0] lk_addr,
  output logic [1:0]                 lk_hit,
  output logic [1:0][DATA_WIDTH-1:0] lk_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  en0;
  logic                  en1;
  logic                  deq;
  logic [PW-1:0]         idx;

  // Register-0 writes never occupy an entry.
  always_comb begin
    ready = (CW'(DEPTH) - count) >= CW'(2);
    empty = (count == '0);
    deq   = !empty;
    en0   = ready && in0_valid && (in0_addr != ADDR_WIDTH'(REG_ZERO));
    en1   = ready && in1_valid && (in1_addr != ADDR_WIDTH'(REG_ZERO));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(en0) + PW'(en1);
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + CW'(en0) + CW'(en1) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (en0) begin
      mem_addr[wr_ptr] <= in0_addr;
      mem_data[wr_ptr] <= in0_data;
    end
    if (en1) begin
      mem_addr[wr_ptr + PW'(en0)] <= in1_addr;
      mem_data[wr_ptr + PW'(en0)] <= in1_data;
    end
  end

  always_comb begin
    head_valid = deq;
    head_addr  = deq ? mem_addr[rd_ptr] : '0;
    head_data  = deq ? mem_data[rd_ptr] : '0;
  end

  // Walk oldest to youngest so the last hit is the youngest write.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    idx     = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (mem_addr[idx] == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Initiator-side controller for dual_port_ram: forwarded operand reads and buffered writebacks.
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned WB_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_ctrl_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_data_a,
  input  logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr_a,
  output logic [DATA_WIDTH-1:0] ram_data_in_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr_b,
  output logic [DATA_WIDTH-1:0] ram_data_in_b
);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_rs1;
  logic [ADDR_WIDTH-1:0] s1_rs2;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_op1;
  logic [DATA_WIDTH-1:0] out_op2;
  logic                  lc_valid;
  logic [ADDR_WIDTH-1:0] lc_addr;
  logic [DATA_WIDTH-1:0] lc_data;

  logic                       stall;
  logic                       accept;
  logic                       advance;
  logic [DATA_WIDTH-1:0]      op1_res;
  logic [DATA_WIDTH-1:0]      op2_res;
  logic                       head_valid;
  logic [ADDR_WIDTH-1:0]      head_addr;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [1:0][ADDR_WIDTH-1:0] lk_addr;
  logic [1:0]                 lk_hit;
  logic [1:0][DATA_WIDTH-1:0] lk_data;

  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  buf_hit,
    input logic [DATA_WIDTH-1:0] buf_data,
    input logic                  c_valid,
    input logic [ADDR_WIDTH-1:0] c_addr,
    input logic [DATA_WIDTH-1:0] c_data,
    input logic [DATA_WIDTH-1:0] rd_data
  );
    if (addr == ADDR_WIDTH'(REG_ZERO)) return '0;
    if (buf_hit)                       return buf_data;
    if (c_valid && (c_addr == addr))   return c_data;
    return rd_data;
  endfunction

  regfile_wbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (bus.wb0_valid),
    .in0_addr   (bus.wb0_addr),
    .in0_data   (bus.wb0_data),
    .in1_valid  (bus.wb1_valid),
    .in1_addr   (bus.wb1_addr),
    .in1_data   (bus.wb1_data),
    .ready      (bus.wb_ready),
    .empty      (bus.wb_empty),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  assign lk_addr[0] = s1_rs1;
  assign lk_addr[1] = s1_rs2;

  // While S1 is stalled the RAM keeps re-reading S1's addresses, so its data stays current.
  always_comb begin
    stall      = s1_valid && out_valid && !bus.rsp_ready;
    accept     = bus.req_valid && !stall;
    advance    = s1_valid && !stall;
    ram_addr_a = stall ? s1_rs1 : bus.req_rs1;
    ram_addr_b = stall ? s1_rs2 : bus.req_rs2;
    op1_res    = resolve(s1_rs1, lk_hit[0], lk_data[0], lc_valid, lc_addr, lc_data, ram_data_a);
    op2_res    = resolve(s1_rs2, lk_hit[1], lk_data[1], lc_valid, lc_addr, lc_data, ram_data_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_rs1   <= bus.req_rs1;
      s1_rs2   <= bus.req_rs2;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
    end else if (!out_valid || bus.rsp_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_op1 <= op1_res;
        out_op2 <= op2_res;
      end
    end
  end

  // Write presented to the RAM last cycle; the RAM read port has not seen it yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      lc_valid <= 1'b0;
      lc_addr  <= '0;
      lc_data  <= '0;
    end else begin
      lc_valid <= head_valid;
      lc_addr  <= head_addr;
      lc_data  <= head_data;
    end
  end

  assign bus.req_ready = !stall;
  assign bus.rsp_valid = out_valid;
  assign bus.rsp_op1   = out_op1;
  assign bus.rsp_op2   = out_op2;

  assign ram_we_a      = head_valid;
  assign ram_addr_wr_a = head_addr;
  assign ram_data_in_a = head_data;
  assign ram_we_b      = 1'b0;
  assign ram_addr_wr_b = '0;
  assign ram_data_in_b = '0;

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

- Initiator-side controller for the team's `dual_port_ram` register file; the RAM is the responder.
- Accepts operand-read requests (two source addresses) over valid/ready and returns both operands over valid/ready.
- Accepts up to two writebacks per cycle, buffers them and drains one per cycle into RAM write port A.
- Forwards buffered and just-committed writes so reads never return stale data, and keeps the RAM's register-0 semantics.

## Interface

Parameters:
- DATA_WIDTH, 32, operand width.
- ADDR_WIDTH, 8, register address width.
- WB_DEPTH, 4, write-buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when both high.
- req_rs1, req_rs2  in  ADDR_WIDTH  source addresses.
- rsp_valid  out  1  operands valid.
- rsp_ready  in  1  consumer accepts.
- rsp_op1, rsp_op2  out  DATA_WIDTH  operands.
- wb0_valid, wb1_valid  in  1  writeback strobes; wb0 is older than wb1.
- wb0_addr, wb1_addr  in  ADDR_WIDTH  writeback addresses.
- wb0_data, wb1_data  in  DATA_WIDTH  writeback data.
- wb_ready  out  1  both writeback ports accepted this cycle.
- wb_empty  out  1  write buffer empty.
- ram_addr_a, ram_addr_b  out  ADDR_WIDTH  RAM read addresses.
- ram_data_a, ram_data_b  in  DATA_WIDTH  RAM read data, registered in the RAM with 1-cycle latency.
- ram_we_a  out  1  RAM port-A write enable.
- ram_addr_wr_a  out  ADDR_WIDTH  RAM port-A write address.
- ram_data_in_a  out  DATA_WIDTH  RAM port-A write data.
- ram_we_b  out  1  tied 0.
- ram_addr_wr_b  out  ADDR_WIDTH  tied 0.
- ram_data_in_b  out  DATA_WIDTH  tied 0.

## Operation

**Read pipeline:** two stages, S1 (RAM read in flight) and OUT (response register).
- `req_ready = !(s1_valid && out_valid && !rsp_ready)`.
- In the accept cycle, `ram_addr_a/b` are driven combinationally from `req_rs1/rs2`.
- When S1 is stalled, `ram_addr_a/b` are driven from S1's registered addresses, so the RAM re-reads every cycle. No separate hold register is needed.
- S1→OUT transfer occurs when `!out_valid || rsp_ready`. Each operand is resolved in this priority order:
  1. Address 0 → 0.
  2. Youngest matching write-buffer entry.
  3. Last-commit register: the write presented to RAM in the previous cycle, which the RAM read has not yet observed.
  4. `ram_data_a/b`.
- Visibility: a read sees every writeback accepted in cycles strictly before its S1→OUT transfer cycle. Writebacks accepted in the transfer cycle are not visible.

**Write buffer:** FIFO of WB_DEPTH entries.
- `wb_ready` = free entries ≥ 2.
- When `wb_ready` is high, the valid writebacks enqueue in that cycle, wb0 before wb1.
- Writes to address 0 are dropped at enqueue and consume no entry.
- Same address on wb0 and wb1: both enqueue; wb1 wins forwarding and the final RAM value.
- Head drains every cycle the buffer is non-empty: `ram_we_a = 1`, `ram_addr_wr_a`/`ram_data_in_a` = head.
- The drained entry is copied into the last-commit register, which is valid for exactly one cycle.
- Enqueue and dequeue in the same cycle are allowed; the count updates by the net amount.

**Reset:** synchronous. Clears S1, OUT, the buffer and the last-commit register. In-flight reads and buffered writes are discarded.

## Timing

- Read latency: request accepted in cycle N → `rsp_valid` high in cycle N+2. Throughput is one per cycle when `rsp_ready` is held high.
- Write: accepted in cycle N into an empty buffer → `ram_we_a` high in cycle N+1 → RAM updated at the end of N+1.
- Two writebacks accepted together drain in N+1 and N+2.
- Reset values:
  - `rsp_valid` = 0; `rsp_op1/2` = 0.
  - `ram_we_a` = 0; `ram_addr_wr_a` = 0; `ram_data_in_a` = 0.
  - `wb_empty` = 1; `wb_ready` = 1.
  - `req_ready` = 1 in the first cycle after reset.
- `rsp_op1/2` are held stable while `rsp_valid && !rsp_ready`.

## Structure

- **Package `regfile_pkg`:** default DATA_WIDTH/ADDR_WIDTH constants, `REG_ZERO` address constant, and `wb_entry_t` {addr, data}.
- **Sub-module `regfile_wbuf`:**
  - Write-buffer FIFO with 2-in/1-out enqueue.
  - Head output.
  - Two combinational youngest-match lookup ports, returning hit and data per port.

## Test plan

1. **Register 0 forced to zero:** write x0 = 0xDEAD via wb0, then read rs1 = 0, rs2 = 0 → enqueue dropped, `wb_empty` stays 1, response 0/0.
2. **Back-to-back reads:** preload R5 = 0x11, R6 = 0x22; issue 4 consecutive requests (5,6) with `rsp_ready` = 1 → responses in cycles N+2..N+5, all 0x11/0x22.
3. **Forwarding hazard:**
   - Cycle N: wb0 R7 = 0xAAAA.
   - Cycle N+1: request (7,7).
   - Expected response 0xAAAA/0xAAAA, from the last-commit path.
   - Repeat with the request issued in cycle N → expected 0xAAAA via buffer forwarding.
4. **Dual write to same address:** wb0 R9 = 1 and wb1 R9 = 2 in the same cycle, request (9,9) next cycle → response 2/2; RAM writes 1 then 2 in consecutive cycles.
5. **Backpressure:**
   - Hold `rsp_ready` = 0 for 5 cycles with 3 requests pending → `req_ready` drops after the 2nd accept and OUT is held stable.
   - A write to S1's register during the stall is reflected when S1 advances.
6. **Full buffer and reset:**
   - Fill the buffer with `ram_we_a` observed draining → `wb_ready` = 0 at ≥ WB_DEPTH−1 entries.
   - Assert `rst` mid-operation → next cycle `rsp_valid` = 0, `wb_empty` = 1, `ram_we_a` = 0.
